// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// -----------------
// Serializes the hart's instruction-fetch and data-access request streams onto
// one single-ported memory device. One requester is granted at a time. When both
// requesters are pending, the one that did not win last time gets the grant.
// The device select is held for the whole transaction. Read data is returned
// from a register. An error response is produced if the device stays silent for
// TIMEOUT busy cycles.
//
// Parameters:
//   TIMEOUT           maximum BUSY cycles without mem_data_ready (1..255)
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   ifetch_req_*      fetch request (valid held with address until response)
//   ifetch_resp_*     fetch response: one-cycle ready pulse, data, timeout error
//   dmem_req_*        data-access request, same protocol as fetch
//   dmem_resp_*       data-access response, same protocol as fetch
//   mem_select        device select, high throughout BUSY
//   mem_addr          granted address during BUSY, otherwise 0
//   mem_data_ready    device response strobe (only honoured in BUSY)
//   mem_data          device read data, sampled with mem_data_ready
//
// Every output is decoded from registers only, so no input reaches an output
// combinationally.

module riscv_mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifetch_req_valid,
    input  logic [31:0] ifetch_req_addr,
    output logic        ifetch_resp_ready,
    output logic [31:0] ifetch_resp_data,
    output logic        ifetch_resp_err,
    input  logic        dmem_req_valid,
    input  logic [31:0] dmem_req_addr,
    output logic        dmem_resp_ready,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err,
    output logic        mem_select,
    output logic [31:0] mem_addr,
    input  logic        mem_data_ready,
    input  logic [31:0] mem_data
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_reg;
    logic        grant_reg;       // 0 = fetch, 1 = dmem
    logic        last_grant_reg;
    logic [31:0] addr_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [7:0]  cnt_reg;

    // Arbitration: a lone requester wins outright. On a tie the requester that
    // did not win last time is chosen, which gives strict alternation under
    // sustained contention.
    logic        any_req;
    logic        winner;
    logic [31:0] winner_addr;

    always_comb begin
        any_req = ifetch_req_valid | dmem_req_valid;
        winner  = 1'b0;
        if (ifetch_req_valid && dmem_req_valid) begin
            winner = ~last_grant_reg;
        end else begin
            winner = dmem_req_valid;
        end
        winner_addr = winner ? dmem_req_addr : ifetch_req_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
            addr_reg       <= 32'd0;
            rdata_reg      <= 32'd0;
            err_reg        <= 1'b0;
            cnt_reg        <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_reg      <= winner;
                        last_grant_reg <= winner;
                        addr_reg       <= winner_addr;
                        cnt_reg        <= 8'd1;
                        state_reg      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A device answer in the final allowed cycle still counts
                    // as success, so the data check comes before the timeout.
                    if (mem_data_ready) begin
                        rdata_reg <= mem_data;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Device side
    assign mem_select = (state_reg == ST_BUSY);
    assign mem_addr   = (state_reg == ST_BUSY) ? addr_reg : 32'd0;

    // Response side: index 0 is fetch, index 1 is dmem. Only the granted
    // port sees anything during RESP. The other port stays all-zero.
    logic [1:0]  resp_ready_vec;
    logic [1:0]  resp_err_vec;
    logic [31:0] resp_data_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign resp_ready_vec[gi] = (state_reg == ST_RESP) && (grant_reg == 1'(gi));
        assign resp_err_vec[gi]   = resp_ready_vec[gi] & err_reg;
        assign resp_data_vec[gi]  = resp_ready_vec[gi] ? rdata_reg : 32'd0;
    end

    assign ifetch_resp_ready = resp_ready_vec[0];
    assign ifetch_resp_err   = resp_err_vec[0];
    assign ifetch_resp_data  = resp_data_vec[0];
    assign dmem_resp_ready   = resp_ready_vec[1];
    assign dmem_resp_err     = resp_err_vec[1];
    assign dmem_resp_data    = resp_data_vec[1];

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter (TIMEOUT = 4).
// A small reference model tracks the pending requests and the last winner. It
// predicts, cycle by cycle, the full output bundle from the arbitration and
// timing rules.

module tb_riscv_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifetch_req_valid = 1'b0;
    logic [31:0] ifetch_req_addr = 32'd0;
    logic        ifetch_resp_ready;
    logic [31:0] ifetch_resp_data;
    logic        ifetch_resp_err;
    logic        dmem_req_valid = 1'b0;
    logic [31:0] dmem_req_addr = 32'd0;
    logic        dmem_resp_ready;
    logic [31:0] dmem_resp_data;
    logic        dmem_resp_err;
    logic        mem_select;
    logic [31:0] mem_addr;
    logic        mem_data_ready = 1'b0;
    logic [31:0] mem_data = 32'd0;

    riscv_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ifetch_req_valid  (ifetch_req_valid),
        .ifetch_req_addr   (ifetch_req_addr),
        .ifetch_resp_ready (ifetch_resp_ready),
        .ifetch_resp_data  (ifetch_resp_data),
        .ifetch_resp_err   (ifetch_resp_err),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_resp_ready   (dmem_resp_ready),
        .dmem_resp_data    (dmem_resp_data),
        .dmem_resp_err     (dmem_resp_err),
        .mem_select        (mem_select),
        .mem_addr          (mem_addr),
        .mem_data_ready    (mem_data_ready),
        .mem_data          (mem_data)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {fetch ready, err, data, dmem ready, err, data, select, addr}
    logic [100:0] obs;
    assign obs = {ifetch_resp_ready, ifetch_resp_err, ifetch_resp_data,
                  dmem_resp_ready, dmem_resp_err, dmem_resp_data,
                  mem_select, mem_addr};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          f_pend = 0;
    bit          d_pend = 0;
    logic [31:0] f_addr = 0;
    logic [31:0] d_addr = 0;
    bit          last_win = 0;   // 0 = fetch, 1 = dmem

    function automatic logic [100:0] mk_exp(input logic fr, input logic fe, input logic [31:0] fd,
                                            input logic dr, input logic de, input logic [31:0] dd,
                                            input logic sel, input logic [31:0] ad);
        return {fr, fe, fd, dr, de, dd, sel, ad};
    endfunction

    // One complete transaction, started at a negedge while the DUT is in IDLE.
    // rf/rd raise a new request on that port if it is not already pending.
    // The device answers in BUSY cycle k. Any k > TO means it never answers.
    task automatic do_txn(input string name, input bit rf, input bit rd,
                          input logic [31:0] af, input logic [31:0] ad,
                          input int k, input logic [31:0] dval);
        bit          win;
        logic [31:0] a;
        int          ke;
        bit          e_err;
        logic [31:0] e_data;
        logic [100:0] exp_v;
        if (rf && !f_pend) begin f_pend = 1; f_addr = af; end
        if (rd && !d_pend) begin d_pend = 1; d_addr = ad; end
        ifetch_req_valid = f_pend; ifetch_req_addr = f_addr;
        dmem_req_valid   = d_pend; dmem_req_addr   = d_addr;
        win = (f_pend && d_pend) ? !last_win : d_pend;
        a = win ? d_addr : f_addr;
        last_win = win;
        ke = (k <= TO) ? k : TO;
        @(posedge clk);
        for (int j = 1; j <= ke; j++) begin
            @(negedge clk);
            exp_v = mk_exp(0, 0, 0, 0, 0, 0, 1, a);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL %s busy%0d: got %h want %h", name, j, obs, exp_v);
            end
            if (j == k) begin
                mem_data_ready = 1'b1; mem_data = dval;
            end else begin
                mem_data_ready = 1'b0; mem_data = $urandom;
            end
        end
        @(negedge clk);
        mem_data_ready = 1'b0;
        mem_data = $urandom;
        e_err  = (k > TO);
        e_data = e_err ? 32'd0 : dval;
        exp_v = win ? mk_exp(0, 0, 0, 1, e_err, e_data, 0, 0)
                    : mk_exp(1, e_err, e_data, 0, 0, 0, 0, 0);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s resp: got %h want %h (win=%0d)", name, obs, exp_v, win);
        end
        $display("[TB] %s: grant=%s addr=%h k=%0d err=%0d data=%h", name, win ? "dmem" : "fetch", a, k, e_err, e_data);
        if (win) begin d_pend = 0; dmem_req_valid = 1'b0; end
        else begin f_pend = 0; ifetch_req_valid = 1'b0; end
        @(negedge clk);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL %s idle: got %h want 0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 0", obs);
        end
        last_win = 0;
        $display("[TB] reset checked");
    endtask

    task automatic test_single_fetch();
        do_txn("single_fetch", 1, 0, 32'h8000, 0, 1, 32'hDEADBEEF);
    endtask

    task automatic test_tie();
        do_txn("tie_dmem", 1, 1, 32'h8000, 32'h8010, 3, 32'h1111_2222);
        do_txn("tie_fetch", 0, 0, 0, 0, 2, 32'h3333_4444);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_txn("contention", 1, 1, $urandom, $urandom, $urandom_range(1, 3), $urandom);
    endtask

    task automatic test_timeout();
        do_txn("timeout", 0, 1, 0, 32'hA000_0040, 100, 32'h5555_5555);
        do_txn("late_answer", 0, 1, 0, 32'hA000_0044, TO, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_mid_busy();
        // Fetch alone first so that the following tie goes to dmem and leaves
        // last winner = dmem; the reset must clear that.
        do_txn("pre_fetch", 1, 0, 32'h100, 0, 1, 32'h77);
        f_pend = 1; f_addr = 32'h200; d_pend = 1; d_addr = 32'h300;
        ifetch_req_valid = 1'b1; ifetch_req_addr = f_addr;
        dmem_req_valid   = 1'b1; dmem_req_addr   = d_addr;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== mk_exp(0, 0, 0, 0, 0, 0, 1, 32'h300)) begin
            n_fail++;
            $display("FAIL rst_busy1: got %h want dmem busy", obs);
        end
        @(negedge clk);
        rst_n = 1'b0;
        mem_data_ready = 1'b1; mem_data = 32'h9999;
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0", obs);
        end
        @(negedge clk);
        mem_data_ready = 1'b0;
        ifetch_req_valid = 1'b0; dmem_req_valid = 1'b0;
        f_pend = 0; d_pend = 0; last_win = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL rst_no_resp%0d: got %h want 0", i, obs);
            end
        end
        $display("[TB] reset mid-busy checked");
        do_txn("post_rst_tie", 1, 1, 32'h400, 32'h500, 2, 32'hABCD);
        do_txn("post_rst_fetch", 0, 0, 0, 0, 1, 32'hBCDE);
    endtask

    task automatic test_stray_strobe();
        mem_data_ready = 1'b1; mem_data = 32'h1234;
        @(negedge clk);
        mem_data_ready = 1'b0; mem_data = 32'h0;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL stray_strobe: got %h want 0", obs);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL stray_after: got %h want 0", obs);
        end
        $display("[TB] stray strobe checked");
        do_txn("after_stray", 0, 1, 0, 32'h600, 1, 32'h0BAD_CAFE);
    endtask

    task automatic test_random();
        bit rf, rd;
        for (int i = 0; i < 30; i++) begin
            rf = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            if (!rf && !rd && !f_pend && !d_pend) rd = 1;
            do_txn("random", rf, rd, $urandom, $urandom, $urandom_range(1, 6), $urandom);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        test_stray_strobe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Serializes the hart's instruction-fetch and memacc request streams onto one single-ported memory target, such as main memory, so that simultaneous fetch and load traffic to the same device never collides. The block sits between the hart's two request ports and the shared device port. It grants one requester at a time with alternating priority on ties. It holds the device select for the whole transaction, returns registered data, and signals an error if the device fails to answer within a bounded number of cycles.

## Interface
Parameters:
- TIMEOUT, default 64: maximum number of BUSY cycles allowed without `mem_data_ready`. Legal range is 1..255.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- ifetch_req_valid, input, 1: fetch request pending. Held until the response, together with its address.
- ifetch_req_addr, input, 32: fetch address.
- ifetch_resp_ready, output, 1: one-cycle pulse; fetch response valid.
- ifetch_resp_data, output, 32: fetch data. Nonzero only while `ifetch_resp_ready` is high.
- ifetch_resp_err, output, 1: qualifies `ifetch_resp_ready`; 1 means timeout.
- dmem_req_valid, input, 1: memacc request pending. Same rules as fetch.
- dmem_req_addr, input, 32: memacc address.
- dmem_resp_ready, output, 1: one-cycle pulse; memacc response valid.
- dmem_resp_data, output, 32: memacc data. Nonzero only while `dmem_resp_ready` is high.
- dmem_resp_err, output, 1: qualifies `dmem_resp_ready`; 1 means timeout.
- mem_select, output, 1: device select, held high for the whole BUSY state.
- mem_addr, output, 32: latched address of the granted request. 0 when not BUSY.
- mem_data_ready, input, 1: device response strobe.
- mem_data, input, 32: device read data, sampled when `mem_data_ready` is high.

## Operation
States:
- IDLE: nothing outstanding; requests are arbitrated here.
- BUSY: one request granted and presented to the device.
- RESP: one-cycle response to the granted requester.

Registers:
- `state`.
- `grant`: 0 = fetch, 1 = dmem.
- `last_grant`.
- `addr_q` (32 bits).
- `rdata_q` (32 bits).
- `err_q`.
- `cnt` (8 bits).

IDLE:
- Only one valid request: grant it.
- Both valid: grant the opposite of `last_grant`.
- On any grant: `addr_q` <= the granted requester's address, `grant` and `last_grant` <= the winner, `cnt` <= 1, next state BUSY.
- No valid request: stay in IDLE.

BUSY:
- `mem_select` = 1 and `mem_addr` = `addr_q`.
- If `mem_data_ready`: `rdata_q` <= `mem_data`, `err_q` <= 0, next state RESP.
- Else if `cnt` == TIMEOUT: `rdata_q` <= 0, `err_q` <= 1, next state RESP.
- Else: `cnt` <= `cnt` + 1.
- `mem_data_ready` takes precedence over the timeout when both occur in the same cycle.

RESP:
- Assert `<grant>_resp_ready` = 1, `<grant>_resp_data` = `rdata_q`, `<grant>_resp_err` = `err_q`.
- All outputs of the other port stay 0.
- Next state is always IDLE.

Requester rules:
- A requester drops valid in the cycle after its ready pulse.
- If valid is still high in IDLE, it is treated as a new request.
- Request inputs are ignored outside IDLE. The losing requester simply stays pending.

Other rules:
- `mem_data_ready` outside BUSY is ignored and has no effect on state or outputs.
- Reset, asserted at any time including mid-transaction:
  - State goes immediately to IDLE.
  - `last_grant` = 0, so dmem wins the first tie.
  - `addr_q`, `rdata_q`, `err_q`, `grant` = 0 and `cnt` = 0.
  - Every output is 0. Any in-flight transaction is dropped with no response.

## Timing
- Request sampled in IDLE at cycle 0.
- `mem_select` is high from cycle 1 through cycle k, where `mem_data_ready` is first high at cycle k (k ≥ 1).
- Response pulse at cycle k+1; IDLE at cycle k+2.
- Minimum latency from request to response is 2 cycles. Back-to-back transactions start every k+2 cycles.
- Timeout: with no `mem_data_ready`, `mem_select` is high for exactly TIMEOUT cycles, and the error response comes at cycle TIMEOUT+1.
- Fairness: with both requesters continuously pending, grants strictly alternate dmem, fetch, dmem, and so on. Neither requester waits more than one transaction.
- All outputs are decoded from registered state and registers. There is no combinational path from inputs to outputs.

## Test plan
- Single fetch: fetch request to 0x8000 with the device answering 0xDEADBEEF at k=1.
  - Expect `mem_select` high for 1 cycle with `mem_addr` = 0x8000.
  - Expect `ifetch_resp_ready` at cycle 2 with data 0xDEADBEEF and err=0; all dmem outputs stay 0.
- Tie after reset: both requests raised at cycle 0 (fetch 0x8000, dmem 0x8010), device latency k=3.
  - Expect the dmem response at cycle 4 with `mem_addr` = 0x8010.
  - Then fetch is granted and `mem_addr` = 0x8000 from cycle 6.
- Sustained contention: both requesters continuously valid for 6 transactions.
  - Expect grant order D, F, D, F, D, F and no gaps beyond the IDLE cycle.
- Timeout: TIMEOUT=4, dmem request, device never responds.
  - Expect `mem_select` high for exactly 4 cycles, then `dmem_resp_ready`=1 with err=1 and data 0.
  - A `mem_data_ready` arriving at the 4th BUSY cycle instead must give err=0 and return the data.
- Reset mid-BUSY: assert `rst_n`=0 in BUSY cycle 2.
  - Expect all outputs 0 immediately and no response pulse afterwards.
  - After release, a tie again goes to dmem first.
- Stray strobe: pulse `mem_data_ready` with 0x1234 while in IDLE.
  - Expect no response pulse and no state change.
  - Expect the next real transaction to return the device's new data, not 0x1234.
